// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared types and default sizes for the vector data memory controller
package vec_mem_pkg;

    localparam int N_DEF     = 8;
    localparam int R_DEF     = 6;
    localparam int DEPTH_DEF = 10930;
    localparam int AW_DEF    = 32;

    typedef logic [N_DEF-1:0] lane_t;
    typedef lane_t [R_DEF-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2
    } dump_state_t;

endpackage

// File: rtl/dump_streamer.sv
// rtl/dump_streamer.sv - dump engine: range check, fetch/present FSM, valid/ready handshake
module dump_streamer
    import vec_mem_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          dump_start,
    input  logic [AW-1:0] dump_base,
    input  logic [AW-1:0] dump_len,
    input  logic          dump_ready,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic [N-1:0]  rd_data,
    output logic          dump_valid,
    output logic [N-1:0]  dump_data,
    output logic          dump_last,
    output logic          dump_busy,
    output logic          dump_err
);

    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    dump_state_t   state;
    logic [AW-1:0] base_q;
    logic [AW-1:0] len_q;
    logic [AW-1:0] cnt;
    logic [AW:0]   end_x;
    logic          is_last;

    // One extra bit so base+len never wraps before the range compare
    assign end_x   = {1'b0, dump_base} + {1'b0, dump_len};
    assign is_last = (cnt == len_q - AW'(1));

    assign rd_req     = (state == FETCH) && !stall;
    assign rd_addr    = base_q + cnt;
    assign dump_valid = (state == PRESENT);
    assign dump_last  = dump_valid && is_last;
    assign dump_busy  = (state != IDLE);

    // FSM: accept/reject start, fetch when the CPU is not writing, hold each element until accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            cnt       <= '0;
            dump_data <= '0;
            dump_err  <= 1'b0;
        end else begin
            dump_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_start && (dump_len != '0)) begin
                        if (end_x > DEPTH_X) begin
                            dump_err <= 1'b1;
                        end else begin
                            base_q <= dump_base;
                            len_q  <= dump_len;
                            cnt    <= '0;
                            state  <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (!stall) begin
                        dump_data <= rd_data;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (dump_ready) begin
                        if (is_last) begin
                            state <= IDLE;
                        end else begin
                            cnt   <= cnt + AW'(1);
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vec_dmem_ctrl.sv
// rtl/vec_dmem_ctrl.sv - vector data memory: R-lane CPU port with bounds masking plus dump read-out
module vec_dmem_ctrl
    import vec_mem_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int R     = R_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [R*N-1:0] cpu_wd,
    output logic [R*N-1:0] cpu_rd,
    output logic          cpu_oob,
    input  logic          dump_start,
    input  logic [AW-1:0] dump_base,
    input  logic [AW-1:0] dump_len,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [N-1:0]  dump_data,
    output logic          dump_last,
    output logic          dump_busy,
    output logic          dump_err
);

    localparam int          IW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [AW:0]   lane_addr [R];
    logic [R-1:0]  lane_ok;

    logic          dump_rd_req;
    logic [AW-1:0] dump_rd_addr;
    logic          dump_rd_ok;
    logic [N-1:0]  dump_rd_data;

    // Per-lane element address in AW+1 bits and its in-range flag
    always_comb begin
        lane_ok = '0;
        for (int i = 0; i < R; i++) begin
            lane_addr[i] = {1'b0, cpu_addr} + (AW+1)'(i);
            lane_ok[i]   = (lane_addr[i] < DEPTH_X);
        end
    end

    // CPU write: only in-range lanes commit; the array has no reset
    always_ff @(posedge clk) begin
        if (cpu_we) begin
            for (int i = 0; i < R; i++) begin
                if (lane_ok[i]) begin
                    mem[lane_addr[i][IW-1:0]] <= cpu_wd[i*N +: N];
                end
            end
        end
    end

    // CPU read: registered, old data on same-cycle write, out-of-range lanes read zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rd  <= '0;
            cpu_oob <= 1'b0;
        end else begin
            for (int i = 0; i < R; i++) begin
                cpu_rd[i*N +: N] <= lane_ok[i] ? mem[lane_addr[i][IW-1:0]] : '0;
            end
            cpu_oob <= ~&lane_ok;
        end
    end

    assign dump_rd_ok   = dump_rd_req && (dump_rd_addr < AW'(DEPTH));
    assign dump_rd_data = dump_rd_ok ? mem[dump_rd_addr[IW-1:0]] : '0;

    // A CPU write stalls the dump fetch so the CPU always owns the array that cycle
    dump_streamer #(
        .N     (N),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_dump (
        .clk        (clk),
        .reset      (reset),
        .stall      (cpu_we),
        .dump_start (dump_start),
        .dump_base  (dump_base),
        .dump_len   (dump_len),
        .dump_ready (dump_ready),
        .rd_req     (dump_rd_req),
        .rd_addr    (dump_rd_addr),
        .rd_data    (dump_rd_data),
        .dump_valid (dump_valid),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .dump_busy  (dump_busy),
        .dump_err   (dump_err)
    );

endmodule
